axi4_lite_master_v2: RTL and testbench
======================================

Name: axi4_lite_master_v2

Overview:
Parametrised AXI4-Lite master engine with independent write and read paths. Each path registers its request on a start pulse and drives the AXI handshakes to completion. It returns the response code, read data, and a one-cycle done pulse, and recovers from a hung slave via a per-transaction timeout. It sits between local control logic (register sequencers, DMA descriptors) and the AXI4-Lite interconnect, and replaces the fixed 32-bit master.

Parameters:
ADDR_W, 32, address width of AW/AR channels and request ports
DATA_W, 32, data width; legal values 32 or 64; strobe width is DATA_W/8
TIMEOUT, 256, max cycles from start to done per transaction; 0 disables timeout; counter width clog2(TIMEOUT+1)

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous reset, active-high
iWRITE_START  in  1  write request pulse; accepted only when oWRITE_BUSY=0
iWRITE_ADDR  in  ADDR_W  write address, sampled on accept
iWRITE_DATA  in  DATA_W  write data, sampled on accept
iWRITE_STRB  in  DATA_W/8  byte strobes, sampled on accept
iWRITE_PROT  in  3  AWPROT value, sampled on accept
oWRITE_BUSY  out  1  write path not idle
oWRITE_DONE  out  1  one-cycle pulse at write completion or timeout
oWRITE_RESP  out  2  BRESP of last write; 2'b10 on timeout; held until next done
oWRITE_TIMEOUT  out  1  last write ended by timeout; held until next done
iREAD_START  in  1  read request pulse; accepted only when oREAD_BUSY=0
iREAD_ADDR  in  ADDR_W  read address, sampled on accept
iREAD_PROT  in  3  ARPROT value, sampled on accept
oREAD_BUSY  out  1  read path not idle
oREAD_DONE  out  1  one-cycle pulse at read completion or timeout
oREAD_DATA  out  DATA_W  RDATA of last read; zero on timeout; held until next done
oREAD_RESP  out  2  RRESP of last read; 2'b10 on timeout
oREAD_TIMEOUT  out  1  last read ended by timeout
m_AWVALID/m_AWREADY/m_AWADDR/m_AWPROT  out/in/out/out  1/1/ADDR_W/3  write address channel
m_WVALID/m_WREADY/m_WDATA/m_WSTRB  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel
m_BVALID/m_BREADY/m_BRESP  in/out/in  1/1/2  write response channel
m_ARVALID/m_ARREADY/m_ARADDR/m_ARPROT  out/in/out/out  1/1/ADDR_W/3  read address channel
m_RVALID/m_RREADY/m_RDATA/m_RRESP  in/out/in/in  1/1/DATA_W/2  read data channel

Behaviour:
- Reset (async, iRST=1): all VALID/READY, BUSY, DONE, TIMEOUT flags = 0; RESP = 2'b00; oREAD_DATA = 0; registered addr/data/strb/prot = 0; FSMs to IDLE; counters = 0. Reset mid-transaction aborts immediately with no done pulse.
- AXI outputs come from registers captured at accept, never from live inputs. They are stable while VALID=1.
- Write FSM:
  - W_IDLE: on iWRITE_START, capture request, set AWVALID=WVALID=1, BUSY=1, go W_REQ. Start while busy is ignored.
  - W_REQ: AWVALID drops the cycle after AWREADY&AWVALID. WVALID drops independently the cycle after WREADY&WVALID. AW and W may complete in either order or the same cycle. When both have completed, set BREADY=1 and go W_RESP. BREADY is not asserted earlier.
  - W_RESP: on BVALID&BREADY, BREADY=0, latch BRESP, DONE=1 for one cycle, BUSY=0, go W_IDLE.
- Read FSM:
  - R_IDLE: on iREAD_START, capture request, ARVALID=1, BUSY=1, go R_ADDR.
  - R_ADDR: on ARREADY, ARVALID=0, RREADY=1, go R_DATA.
  - R_DATA: on RVALID&RREADY, RREADY=0, latch RDATA/RRESP, DONE pulse, BUSY=0, go R_IDLE.
- Minimum latency with an always-ready slave: write start to DONE = 3 cycles; read start to DONE = 3 cycles.
- Timeout (TIMEOUT>0), per path:
  - The counter clears on accept and increments each busy cycle.
  - When it reaches TIMEOUT without completion, drop all of that path's VALID/READY, set RESP=2'b10, TIMEOUT=1, DONE pulse, return to IDLE.
  - If completion and timeout coincide in the same cycle, completion wins.
  - Abandoning VALID is deliberate bus-hang recovery.
- Write and read paths are fully independent and may run concurrently. Simultaneous start on both is accepted on both.
- A new start in the same cycle as DONE is ignored (BUSY still 1). The earliest re-accept is the cycle after DONE.

Test Plan:
- Write 0x0000_0010 / 0xDEADBEEF / strb 4'hF, slave always ready, BRESP=00 -> AW, W and B handshakes seen; DONE pulse at cycle 3; oWRITE_RESP=00.
- Read 0x20, slave returns 0x12345678 with RRESP=00 after 5 wait cycles on RVALID -> oREAD_DATA=0x12345678, DONE exactly 1 cycle, BUSY low the next cycle.
- Write with WREADY 4 cycles before AWREADY, then reversed order -> BREADY rises only after both handshakes in both cases; BRESP=2'b10 latched.
- TIMEOUT=8, slave never asserts ARREADY -> ARVALID dropped, DONE at cycle 8, oREAD_RESP=10, oREAD_TIMEOUT=1, oREAD_DATA=0.
- Concurrent write and read start, plus a second iWRITE_START while busy -> both complete; second write ignored; only one AW handshake.
- Assert iRST during W_RESP -> all outputs at reset values asynchronously; no DONE pulse; next write after release completes normally.

Source files
------------

// File: rtl/axi4_lite_master_v2.sv
// axi4_lite_master_v2: AXI4-Lite master with independent, timeout-guarded write and read engines
module axi4_lite_master_v2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iWRITE_START,
  input  logic [ADDR_W-1:0]   iWRITE_ADDR,
  input  logic [DATA_W-1:0]   iWRITE_DATA,
  input  logic [DATA_W/8-1:0] iWRITE_STRB,
  input  logic [2:0]          iWRITE_PROT,
  output logic                oWRITE_BUSY,
  output logic                oWRITE_DONE,
  output logic [1:0]          oWRITE_RESP,
  output logic                oWRITE_TIMEOUT,
  input  logic                iREAD_START,
  input  logic [ADDR_W-1:0]   iREAD_ADDR,
  input  logic [2:0]          iREAD_PROT,
  output logic                oREAD_BUSY,
  output logic                oREAD_DONE,
  output logic [DATA_W-1:0]   oREAD_DATA,
  output logic [1:0]          oREAD_RESP,
  output logic                oREAD_TIMEOUT,
  output logic                m_AWVALID,
  input  logic                m_AWREADY,
  output logic [ADDR_W-1:0]   m_AWADDR,
  output logic [2:0]          m_AWPROT,
  output logic                m_WVALID,
  input  logic                m_WREADY,
  output logic [DATA_W-1:0]   m_WDATA,
  output logic [DATA_W/8-1:0] m_WSTRB,
  input  logic                m_BVALID,
  output logic                m_BREADY,
  input  logic [1:0]          m_BRESP,
  output logic                m_ARVALID,
  input  logic                m_ARREADY,
  output logic [ADDR_W-1:0]   m_ARADDR,
  output logic [2:0]          m_ARPROT,
  input  logic                m_RVALID,
  output logic                m_RREADY,
  input  logic [DATA_W-1:0]   m_RDATA,
  input  logic [1:0]          m_RRESP
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t          r_wstate, w_wstate_nx;
  logic              r_awvalid, w_awvalid_nx;
  logic              r_wvalid, w_wvalid_nx;
  logic              r_bready, w_bready_nx;
  logic              r_wdone, w_wdone_nx;
  logic              r_wto, w_wto_nx;
  logic [1:0]        r_wresp, w_wresp_nx;
  logic [CNT_W-1:0]  r_wcnt, w_wcnt_nx;
  logic [ADDR_W-1:0] r_awaddr;
  logic [2:0]        r_awprot;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              w_wacc, w_wexp, w_aw_hs, w_w_hs, w_b_hs;

  r_state_t          r_rstate, w_rstate_nx;
  logic              r_arvalid, w_arvalid_nx;
  logic              r_rready, w_rready_nx;
  logic              r_rdone, w_rdone_nx;
  logic              r_rto, w_rto_nx;
  logic [1:0]        r_rresp, w_rresp_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx;
  logic [CNT_W-1:0]  r_rcnt, w_rcnt_nx;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arprot;
  logic              w_racc, w_rexp, w_ar_hs, w_r_hs;

  // The DONE cycle still counts as busy, so a start coinciding with DONE is dropped
  assign w_wacc  = (r_wstate == W_IDLE) && !r_wdone && iWRITE_START;
  assign w_aw_hs = r_awvalid && m_AWREADY;
  assign w_w_hs  = r_wvalid && m_WREADY;
  assign w_b_hs  = r_bready && m_BVALID;
  // Fires on the edge that puts DONE at cycle TIMEOUT after the start cycle; completion wins a tie
  assign w_wexp  = (TIMEOUT > 0) && (r_wstate != W_IDLE) && (int'(r_wcnt) + 2 >= TIMEOUT) && !w_b_hs;

  assign w_racc  = (r_rstate == R_IDLE) && !r_rdone && iREAD_START;
  assign w_ar_hs = r_arvalid && m_ARREADY;
  assign w_r_hs  = r_rready && m_RVALID;
  assign w_rexp  = (TIMEOUT > 0) && (r_rstate != R_IDLE) && (int'(r_rcnt) + 2 >= TIMEOUT) && !w_r_hs;

  // Write path next state: AW and W retire independently, B only after both
  always_comb begin
    w_wstate_nx  = r_wstate;
    w_awvalid_nx = r_awvalid && !w_aw_hs;
    w_wvalid_nx  = r_wvalid && !w_w_hs;
    w_bready_nx  = r_bready;
    w_wdone_nx   = 1'b0;
    w_wresp_nx   = r_wresp;
    w_wto_nx     = r_wto;
    w_wcnt_nx    = (r_wstate != W_IDLE && TIMEOUT > 0) ? r_wcnt + CNT_W'(1) : r_wcnt;
    case (r_wstate)
      W_IDLE: if (w_wacc) begin
        w_wstate_nx  = W_REQ;
        w_awvalid_nx = 1'b1;
        w_wvalid_nx  = 1'b1;
        w_wcnt_nx    = '0;
      end
      W_REQ: if (!w_awvalid_nx && !w_wvalid_nx) begin
        w_wstate_nx = W_RESP;
        w_bready_nx = 1'b1;
      end
      W_RESP: if (w_b_hs) begin
        w_wstate_nx = W_IDLE;
        w_bready_nx = 1'b0;
        w_wresp_nx  = m_BRESP;
        w_wto_nx    = 1'b0;
        w_wdone_nx  = 1'b1;
      end
      default: w_wstate_nx = W_IDLE;
    endcase
    if (w_wexp) begin
      w_wstate_nx  = W_IDLE;
      w_awvalid_nx = 1'b0;
      w_wvalid_nx  = 1'b0;
      w_bready_nx  = 1'b0;
      w_wresp_nx   = 2'b10;
      w_wto_nx     = 1'b1;
      w_wdone_nx   = 1'b1;
    end
  end

  // Write path state and status registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_wstate  <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_wdone   <= 1'b0;
      r_wresp   <= 2'b00;
      r_wto     <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      r_wstate  <= w_wstate_nx;
      r_awvalid <= w_awvalid_nx;
      r_wvalid  <= w_wvalid_nx;
      r_bready  <= w_bready_nx;
      r_wdone   <= w_wdone_nx;
      r_wresp   <= w_wresp_nx;
      r_wto     <= w_wto_nx;
      r_wcnt    <= w_wcnt_nx;
    end
  end

  // Write request capture so AW/W payload stays stable while VALID is high
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_awaddr <= '0;
      r_awprot <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (w_wacc) begin
      r_awaddr <= iWRITE_ADDR;
      r_awprot <= iWRITE_PROT;
      r_wdata  <= iWRITE_DATA;
      r_wstrb  <= iWRITE_STRB;
    end
  end

  // Read path next state: AR handshake, then accept one R beat
  always_comb begin
    w_rstate_nx  = r_rstate;
    w_arvalid_nx = r_arvalid;
    w_rready_nx  = r_rready;
    w_rdone_nx   = 1'b0;
    w_rdata_nx   = r_rdata;
    w_rresp_nx   = r_rresp;
    w_rto_nx     = r_rto;
    w_rcnt_nx    = (r_rstate != R_IDLE && TIMEOUT > 0) ? r_rcnt + CNT_W'(1) : r_rcnt;
    case (r_rstate)
      R_IDLE: if (w_racc) begin
        w_rstate_nx  = R_ADDR;
        w_arvalid_nx = 1'b1;
        w_rcnt_nx    = '0;
      end
      R_ADDR: if (w_ar_hs) begin
        w_rstate_nx  = R_DATA;
        w_arvalid_nx = 1'b0;
        w_rready_nx  = 1'b1;
      end
      R_DATA: if (w_r_hs) begin
        w_rstate_nx = R_IDLE;
        w_rready_nx = 1'b0;
        w_rdata_nx  = m_RDATA;
        w_rresp_nx  = m_RRESP;
        w_rto_nx    = 1'b0;
        w_rdone_nx  = 1'b1;
      end
      default: w_rstate_nx = R_IDLE;
    endcase
    if (w_rexp) begin
      w_rstate_nx  = R_IDLE;
      w_arvalid_nx = 1'b0;
      w_rready_nx  = 1'b0;
      w_rdata_nx   = '0;
      w_rresp_nx   = 2'b10;
      w_rto_nx     = 1'b1;
      w_rdone_nx   = 1'b1;
    end
  end

  // Read path state and status registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_rstate  <= R_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdone   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_rto     <= 1'b0;
      r_rcnt    <= '0;
    end else begin
      r_rstate  <= w_rstate_nx;
      r_arvalid <= w_arvalid_nx;
      r_rready  <= w_rready_nx;
      r_rdone   <= w_rdone_nx;
      r_rdata   <= w_rdata_nx;
      r_rresp   <= w_rresp_nx;
      r_rto     <= w_rto_nx;
      r_rcnt    <= w_rcnt_nx;
    end
  end

  // Read request capture so AR payload stays stable while VALID is high
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_araddr <= '0;
      r_arprot <= '0;
    end else if (w_racc) begin
      r_araddr <= iREAD_ADDR;
      r_arprot <= iREAD_PROT;
    end
  end

  assign oWRITE_BUSY    = (r_wstate != W_IDLE) || r_wdone;
  assign oWRITE_DONE    = r_wdone;
  assign oWRITE_RESP    = r_wresp;
  assign oWRITE_TIMEOUT = r_wto;
  assign m_AWVALID      = r_awvalid;
  assign m_AWADDR       = r_awaddr;
  assign m_AWPROT       = r_awprot;
  assign m_WVALID       = r_wvalid;
  assign m_WDATA        = r_wdata;
  assign m_WSTRB        = r_wstrb;
  assign m_BREADY       = r_bready;

  assign oREAD_BUSY     = (r_rstate != R_IDLE) || r_rdone;
  assign oREAD_DONE     = r_rdone;
  assign oREAD_DATA     = r_rdata;
  assign oREAD_RESP     = r_rresp;
  assign oREAD_TIMEOUT  = r_rto;
  assign m_ARVALID      = r_arvalid;
  assign m_ARADDR       = r_araddr;
  assign m_ARPROT       = r_arprot;
  assign m_RREADY       = r_rready;
endmodule

// File: tb/tb_axi4_lite_master_v2.sv
// tb_axi4_lite_master_v2: randomized delay-slave bench with a latency/response reference model
module tb_axi4_lite_master_v2;
  localparam int TMO = 8;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iWRITE_START, iREAD_START;
  logic [31:0] iWRITE_ADDR, iWRITE_DATA, iREAD_ADDR;
  logic [3:0]  iWRITE_STRB;
  logic [2:0]  iWRITE_PROT, iREAD_PROT;
  logic        oWRITE_BUSY, oWRITE_DONE, oWRITE_TIMEOUT;
  logic [1:0]  oWRITE_RESP;
  logic        oREAD_BUSY, oREAD_DONE, oREAD_TIMEOUT;
  logic [31:0] oREAD_DATA;
  logic [1:0]  oREAD_RESP;
  logic        m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_BVALID, m_BREADY;
  logic        m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
  logic [31:0] m_AWADDR, m_WDATA, m_ARADDR, m_RDATA;
  logic [2:0]  m_AWPROT, m_ARPROT;
  logic [3:0]  m_WSTRB;
  logic [1:0]  m_BRESP, m_RRESP;

  int n_cmp = 0;
  int n_bad = 0;

  // slave behaviour knobs and expected request payload
  int          d_aw, d_w, d_b, d_ar, d_r;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  int          aw_hs, w_hs, ar_hs;
  logic [31:0] e_waddr, e_wdata, e_raddr;
  logic [3:0]  e_wstrb;
  logic [2:0]  e_wprot, e_rprot;

  always #5 iCLK = ~iCLK;

  axi4_lite_master_v2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iWRITE_START(iWRITE_START), .iWRITE_ADDR(iWRITE_ADDR), .iWRITE_DATA(iWRITE_DATA),
    .iWRITE_STRB(iWRITE_STRB), .iWRITE_PROT(iWRITE_PROT),
    .oWRITE_BUSY(oWRITE_BUSY), .oWRITE_DONE(oWRITE_DONE), .oWRITE_RESP(oWRITE_RESP),
    .oWRITE_TIMEOUT(oWRITE_TIMEOUT),
    .iREAD_START(iREAD_START), .iREAD_ADDR(iREAD_ADDR), .iREAD_PROT(iREAD_PROT),
    .oREAD_BUSY(oREAD_BUSY), .oREAD_DONE(oREAD_DONE), .oREAD_DATA(oREAD_DATA),
    .oREAD_RESP(oREAD_RESP), .oREAD_TIMEOUT(oREAD_TIMEOUT),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR), .m_AWPROT(m_AWPROT),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
    .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARPROT(m_ARPROT),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // AW slave: READY after d_aw cycles of VALID; checks the presented payload at handshake
  initial begin : aw_slave
    int c;
    c = 0;
    m_AWREADY = 1'b0;
    forever begin
      @(negedge iCLK);
      if (m_AWVALID) begin
        m_AWREADY = (c >= d_aw);
        c++;
        if (m_AWREADY) begin
          aw_hs++;
          chk("aw_addr", m_AWADDR, e_waddr);
          chk("aw_prot", m_AWPROT, e_wprot);
        end
      end else begin
        m_AWREADY = 1'b0;
        c = 0;
      end
    end
  end

  // W slave
  initial begin : w_slave
    int c;
    c = 0;
    m_WREADY = 1'b0;
    forever begin
      @(negedge iCLK);
      if (m_WVALID) begin
        m_WREADY = (c >= d_w);
        c++;
        if (m_WREADY) begin
          w_hs++;
          chk("w_data", m_WDATA, e_wdata);
          chk("w_strb", m_WSTRB, e_wstrb);
        end
      end else begin
        m_WREADY = 1'b0;
        c = 0;
      end
    end
  end

  // B slave: BVALID after d_b cycles of BREADY; BREADY must not precede both AW and W
  initial begin : b_slave
    int c;
    c = 0;
    m_BVALID = 1'b0;
    m_BRESP = 2'b00;
    forever begin
      @(negedge iCLK);
      if (m_BREADY) begin
        if (c == 0) chk("bready_after_aw_w", {aw_hs == 1, w_hs == 1}, 2'b11);
        m_BVALID = (c >= d_b);
        m_BRESP = s_bresp;
        c++;
      end else begin
        m_BVALID = 1'b0;
        c = 0;
      end
    end
  end

  // AR slave
  initial begin : ar_slave
    int c;
    c = 0;
    m_ARREADY = 1'b0;
    forever begin
      @(negedge iCLK);
      if (m_ARVALID) begin
        m_ARREADY = (c >= d_ar);
        c++;
        if (m_ARREADY) begin
          ar_hs++;
          chk("ar_addr", m_ARADDR, e_raddr);
          chk("ar_prot", m_ARPROT, e_rprot);
        end
      end else begin
        m_ARREADY = 1'b0;
        c = 0;
      end
    end
  end

  // R slave: junk data whenever RVALID is low so a premature latch shows up
  initial begin : r_slave
    int c;
    c = 0;
    m_RVALID = 1'b0;
    m_RDATA = 32'h0;
    m_RRESP = 2'b00;
    forever begin
      @(negedge iCLK);
      if (m_RREADY) begin
        m_RVALID = (c >= d_r);
        c++;
      end else begin
        m_RVALID = 1'b0;
        c = 0;
      end
      m_RDATA = m_RVALID ? s_rdata : ~s_rdata;
      m_RRESP = m_RVALID ? s_rresp : ~s_rresp;
    end
  end

  // Reference: DONE lands 3 + max(AW,W wait) + B wait cycles after start, unless that exceeds TMO
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input int daw, input int dw, input int db,
                          input logic [1:0] br, input bit dup);
    int lat, exp_c, got;
    bit tout;
    d_aw = daw; d_w = dw; d_b = db; s_bresp = br;
    e_waddr = a; e_wdata = d; e_wstrb = s; e_wprot = p;
    aw_hs = 0; w_hs = 0;
    lat = 3 + ((daw > dw) ? daw : dw) + db;
    tout = lat > TMO;
    exp_c = tout ? TMO : lat;
    iWRITE_ADDR = a; iWRITE_DATA = d; iWRITE_STRB = s; iWRITE_PROT = p;
    iWRITE_START = 1'b1;
    got = 0;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      @(negedge iCLK);
      iWRITE_START = dup && (k == 1);
      if (dup && k == 1) iWRITE_ADDR = ~a;
      if (oWRITE_DONE) got = k;
    end
    chk("wr_done_cycle", got, exp_c);
    chk("wr_busy_at_done", oWRITE_BUSY, 1'b1);
    chk("wr_resp", oWRITE_RESP, tout ? 2'b10 : br);
    chk("wr_timeout", oWRITE_TIMEOUT, tout);
    if (!tout) begin
      chk("wr_aw_hs", aw_hs, 1);
      chk("wr_w_hs", w_hs, 1);
    end
    iWRITE_START = dup;
    @(negedge iCLK);
    iWRITE_START = 1'b0;
    chk("wr_done_pulse", oWRITE_DONE, 1'b0);
    chk("wr_busy_after", oWRITE_BUSY, 1'b0);
    chk("wr_chan_idle", {m_AWVALID, m_WVALID, m_BREADY}, 3'b000);
    chk("wr_resp_hold", oWRITE_RESP, tout ? 2'b10 : br);
  endtask

  // Reference: DONE lands 3 + AR wait + R wait cycles after start, unless that exceeds TMO
  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int dar, input int dr,
                         input logic [31:0] rd, input logic [1:0] rr);
    int lat, exp_c, got;
    bit tout;
    d_ar = dar; d_r = dr; s_rdata = rd; s_rresp = rr;
    e_raddr = a; e_rprot = p;
    ar_hs = 0;
    lat = 3 + dar + dr;
    tout = lat > TMO;
    exp_c = tout ? TMO : lat;
    iREAD_ADDR = a; iREAD_PROT = p;
    iREAD_START = 1'b1;
    got = 0;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      @(negedge iCLK);
      iREAD_START = 1'b0;
      if (oREAD_DONE) got = k;
    end
    chk("rd_done_cycle", got, exp_c);
    chk("rd_data", oREAD_DATA, tout ? 32'h0 : rd);
    chk("rd_resp", oREAD_RESP, tout ? 2'b10 : rr);
    chk("rd_timeout", oREAD_TIMEOUT, tout);
    if (!tout) chk("rd_ar_hs", ar_hs, 1);
    @(negedge iCLK);
    chk("rd_done_pulse", oREAD_DONE, 1'b0);
    chk("rd_busy_after", oREAD_BUSY, 1'b0);
    chk("rd_chan_idle", {m_ARVALID, m_RREADY}, 2'b00);
    chk("rd_data_hold", oREAD_DATA, tout ? 32'h0 : rd);
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(0, 3));
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int ndone;
    int mode;
    iRST = 1'b1;
    iWRITE_START = 1'b0; iREAD_START = 1'b0;
    iWRITE_ADDR = 0; iWRITE_DATA = 0; iWRITE_STRB = 0; iWRITE_PROT = 0;
    iREAD_ADDR = 0; iREAD_PROT = 0;
    d_aw = 0; d_w = 0; d_b = 0; d_ar = 0; d_r = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0;
    e_waddr = 0; e_wdata = 0; e_raddr = 0; e_wstrb = 0; e_wprot = 0; e_rprot = 0;
    repeat (3) @(negedge iCLK);
    chk("rst_busy", {oWRITE_BUSY, oREAD_BUSY}, 2'b00);
    chk("rst_done", {oWRITE_DONE, oREAD_DONE}, 2'b00);
    chk("rst_valid", {m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY}, 5'b0);
    chk("rst_status", {oWRITE_RESP, oWRITE_TIMEOUT, oREAD_RESP, oREAD_TIMEOUT}, 6'b0);
    chk("rst_rdata", oREAD_DATA, 32'h0);
    iRST = 1'b0;
    @(negedge iCLK);

    do_write(32'h0000_0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, 2'b00, 1'b0);
    do_read(32'h0000_0020, 3'b000, 0, 5, 32'h12345678, 2'b00);
    do_write(32'h0000_0030, 32'hA5A5_0001, 4'h3, 3'b010, 4, 0, 0, 2'b10, 1'b0);
    do_write(32'h0000_0034, 32'h5A5A_0002, 4'hC, 3'b101, 0, 4, 0, 2'b10, 1'b0);
    do_read(32'h0000_0040, 3'b001, 99, 0, 32'hCAFE_F00D, 2'b00);

    // reset while parked in the write response phase
    d_aw = 0; d_w = 0; d_b = 99; s_bresp = 2'b00;
    e_waddr = 32'h50; e_wdata = 32'h1111_2222; e_wstrb = 4'hF; e_wprot = 3'b000;
    aw_hs = 0; w_hs = 0;
    iWRITE_ADDR = 32'h50; iWRITE_DATA = 32'h1111_2222; iWRITE_STRB = 4'hF; iWRITE_PROT = 3'b000;
    iWRITE_START = 1'b1;
    @(negedge iCLK);
    iWRITE_START = 1'b0;
    @(negedge iCLK);
    chk("rst_pre_bready", m_BREADY, 1'b1);
    #2 iRST = 1'b1;
    #1;
    chk("rst_async_busy", {oWRITE_BUSY, oREAD_BUSY}, 2'b00);
    chk("rst_async_chan", {m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY}, 5'b0);
    chk("rst_async_status", {oWRITE_RESP, oWRITE_TIMEOUT, oREAD_RESP, oREAD_TIMEOUT}, 6'b0);
    chk("rst_async_done", {oWRITE_DONE, oREAD_DONE}, 2'b00);
    @(negedge iCLK);
    iRST = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge iCLK);
      if (oWRITE_DONE) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    do_write(32'h0000_0060, 32'h3333_4444, 4'h5, 3'b011, 1, 1, 1, 2'b00, 1'b0);

    fork
      do_write(32'h0000_0070, 32'h7777_8888, 4'hF, 3'b100, 1, 2, 1, 2'b01, 1'b1);
      do_read(32'h0000_0080, 3'b110, 1, 2, 32'h9999_AAAA, 2'b11);
    join

    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        do_write($urandom, $urandom, 4'($urandom), 3'($urandom), rnd_delay(), rnd_delay(),
                 rnd_delay(), 2'($urandom), 1'($urandom));
      end else if (mode == 1) begin
        do_read($urandom, 3'($urandom), rnd_delay(), rnd_delay(), $urandom, 2'($urandom));
      end else begin
        fork
          do_write($urandom, $urandom, 4'($urandom), 3'($urandom), rnd_delay(), rnd_delay(),
                   rnd_delay(), 2'($urandom), 1'($urandom));
          do_read($urandom, 3'($urandom), rnd_delay(), rnd_delay(), $urandom, 2'($urandom));
        join
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
